spi_master_mc: RTL and testbench
================================

Name: spi_master_mc

Overview:
Parametrised SPI master, successor to the single-slave SPI driver. Adds:
- all four CPOL/CPHA modes with identical loopback results in every mode;
- programmable SCLK divider;
- multiple active-low chip selects, chosen per transfer;
- explicit CS setup/hold phases.

It sits between user logic (valid/ready command in, valid pulse out) and up to P_CS_NUM SPI slaves on a shared SCLK/MOSI/MISO bus.

Parameters:
P_DATA_WIDTH, 8: bits per transfer, ≥2.
P_CS_NUM, 4: number of chip selects, ≥1.
P_CLK_DIV, 2: i_clk cycles per SCLK half-period, ≥1.
P_CPOL, 0: SCLK idle level.
P_CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_user_data  in  P_DATA_WIDTH  word to transmit
i_user_cs_sel  in  CSW  slave index; CSW = (P_CS_NUM>1) ? $clog2(P_CS_NUM) : 1
i_user_valid  in  1  command valid
o_ready  out  1  block can accept a command
i_spi_miso  in  1  serial data from slave
o_spi_mosi  out  1  serial data to slave
o_spi_clk  out  1  SCLK
o_cs  out  P_CS_NUM  active-low chip selects
o_user_data  out  P_DATA_WIDTH  received word
o_user_valid  out  1  one-cycle pulse when o_user_data updates

Behaviour:
- All outputs are registered. Reset values:
  - o_ready=1, o_cs=all ones, o_spi_clk=P_CPOL, o_spi_mosi=0;
  - o_user_data=0, o_user_valid=0; FSM=IDLE.
  - Reset mid-transfer aborts at the next edge with the same values. No o_user_valid pulse.
- FSM states and transitions:
  - IDLE: o_ready=1. On i_user_valid & o_ready, latch data and cs_sel, then go to SETUP.
  - SETUP: lasts P_CLK_DIV cycles, then XFER.
  - XFER: lasts 2*P_DATA_WIDTH*P_CLK_DIV cycles, then HOLD.
  - HOLD: lasts P_CLK_DIV cycles, then IDLE.
- Handshake timing (accept edge = cycle T):
  - o_ready=0 from T+1 until return to IDLE.
  - The selected o_cs bit goes low at T+1.
  - CS stays low for exactly (2*P_DATA_WIDTH+2)*P_CLK_DIV cycles.
- SCLK:
  - o_spi_clk toggles at the end of every P_CLK_DIV-cycle half-period in XFER, giving 2*P_DATA_WIDTH toggles.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - SCLK equals P_CPOL in SETUP, HOLD and IDLE.
- Data, MSB first:
  - CPHA=0: MOSI presents the MSB from the start of SETUP. Shift on each trailing edge except the last.
  - CPHA=1: MOSI updates on each leading edge, starting with the MSB.
  - MISO is registered on the same i_clk edge that generates the sampling SCLK edge: leading edge for CPHA=0, trailing edge for CPHA=1.
  - Received bits shift into an internal register, MSB first.
  - MOSI holds its last bit through HOLD and returns to 0 in IDLE.
- Completion:
  - On the cycle CS deasserts (first IDLE cycle), o_user_data is loaded and o_user_valid=1 for one cycle.
  - o_ready=1 in that same cycle, so back-to-back commands are accepted there.
  - Between consecutive transfers CS is high for ≥1 cycle.
- i_user_cs_sel ≥ P_CS_NUM:
  - The transfer runs with normal timing, but no o_cs bit asserts.
  - o_user_valid still pulses, carrying the sampled MISO value.
- i_user_valid while o_ready=0 is ignored; the command is not queued.
- Input data and cs_sel are captured only at accept. Later input changes have no effect.

Optional Feature:
Macro SPI_LSB_FIRST_EN.
- Defined: transmit and receive LSB first. Bit 0 goes out first and the first sampled bit lands in o_user_data[0].
- Undefined: MSB first, as specified above.
- Timing, CS and handshake behaviour are identical in both cases.

Test Plan:
1. Loopback (MOSI tied to MISO), W=8, DIV=2, each of the four CPOL/CPHA combinations, send 8'hA5 on cs 0 -> o_user_data=8'hA5 and a single o_user_valid pulse; o_cs[0] low exactly 36 cycles; 16 SCLK toggles; SCLK idles at CPOL.
2. Slave model drives 8'h3C, mode 3, cs_sel=2 -> o_user_data=8'h3C; only o_cs[2] toggles; o_cs stays 4'b1111 outside the transfer.
3. Hold i_user_valid high with 8'h01 then 8'hFE -> second accept occurs in the o_user_valid cycle; both words are received; CS is high ≥1 cycle between transfers.
4. P_CS_NUM=3, cs_sel=3 -> o_cs stays 3'b111; SCLK and MOSI run normally; o_user_valid pulses once.
5. Assert i_rst at SCLK toggle 5 -> next cycle o_cs all ones, o_spi_clk=CPOL, o_ready=1; no o_user_valid; the next transfer of 8'h5A loops back correctly.
6. With SPI_LSB_FIRST_EN, send 8'h01 -> first MOSI bit is 1; loopback returns 8'h01.

Source files
------------

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master with CPOL/CPHA modes, SCLK divider and CS setup/hold phases.
// Optional build macro SPI_LSB_FIRST_EN switches both directions to LSB-first shifting.
module spi_master_mc #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CS_NUM     = 4,
    parameter int P_CLK_DIV    = 2,
    parameter bit P_CPOL       = 1'b0,
    parameter bit P_CPHA       = 1'b0,
    localparam int CSW         = (P_CS_NUM > 1) ? $clog2(P_CS_NUM) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_user_data,
    input  logic [CSW-1:0]          i_user_cs_sel,
    input  logic                    i_user_valid,
    output logic                    o_ready,
    input  logic                    i_spi_miso,
    output logic                    o_spi_mosi,
    output logic                    o_spi_clk,
    output logic [P_CS_NUM-1:0]     o_cs,
    output logic [P_DATA_WIDTH-1:0] o_user_data,
    output logic                    o_user_valid
);

    localparam int DIVW  = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam int EDGES = 2 * P_DATA_WIDTH;
    localparam int EW    = $clog2(EDGES);
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(P_CLK_DIV - 1);
    localparam logic [EW-1:0]   EDGE_LAST = EW'(EDGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic first_bit(input logic [P_DATA_WIDTH-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return v[0];
`else
        return v[P_DATA_WIDTH-1];
`endif
    endfunction

    function automatic logic [P_DATA_WIDTH-1:0] tx_advance(input logic [P_DATA_WIDTH-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return {1'b0, v[P_DATA_WIDTH-1:1]};
`else
        return {v[P_DATA_WIDTH-2:0], 1'b0};
`endif
    endfunction

    // After P_DATA_WIDTH inserts the first received bit sits at the MSB (or bit 0 when LSB-first).
    function automatic logic [P_DATA_WIDTH-1:0] rx_insert(input logic [P_DATA_WIDTH-1:0] v,
                                                          input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, v[P_DATA_WIDTH-1:1]};
`else
        return {v[P_DATA_WIDTH-2:0], b};
`endif
    endfunction

    // An out-of-range index yields no asserted select, so the transfer runs unaddressed.
    function automatic logic [P_CS_NUM-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [P_CS_NUM-1:0] m;
        m = {P_CS_NUM{1'b1}};
        for (int i = 0; i < P_CS_NUM; i++) begin
            if (sel == CSW'(i)) begin
                m[i] = 1'b0;
            end else begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    state_t                  state_r, state_s;
    logic [DIVW-1:0]         div_cnt_r, div_cnt_s;
    logic [EW-1:0]           edge_cnt_r, edge_cnt_s;
    logic [P_DATA_WIDTH-1:0] tx_r, tx_s;
    logic [P_DATA_WIDTH-1:0] rx_r, rx_s;
    logic                    ready_r, ready_s;
    logic [P_CS_NUM-1:0]     cs_r, cs_s;
    logic                    sclk_r, sclk_s;
    logic                    mosi_r, mosi_s;
    logic [P_DATA_WIDTH-1:0] udata_r, udata_s;
    logic                    uvalid_r, uvalid_s;
    logic                    half_end_s;
    logic                    leading_s;

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        div_cnt_s  = div_cnt_r;
        edge_cnt_s = edge_cnt_r;
        tx_s       = tx_r;
        rx_s       = rx_r;
        ready_s    = ready_r;
        cs_s       = cs_r;
        sclk_s     = sclk_r;
        mosi_s     = mosi_r;
        udata_s    = udata_r;
        uvalid_s   = 1'b0;
        half_end_s = (div_cnt_r == DIV_LAST);
        // edge_cnt_r counts toggles already made, so an even count means the next one leads.
        leading_s  = ~edge_cnt_r[0];

        case (state_r)
            ST_IDLE: begin
                ready_s    = 1'b1;
                cs_s       = {P_CS_NUM{1'b1}};
                sclk_s     = P_CPOL;
                mosi_s     = 1'b0;
                div_cnt_s  = {DIVW{1'b0}};
                edge_cnt_s = {EW{1'b0}};
                if (i_user_valid && ready_r) begin
                    state_s = ST_SETUP;
                    ready_s = 1'b0;
                    cs_s    = cs_decode(i_user_cs_sel);
                    tx_s    = i_user_data;
                    rx_s    = {P_DATA_WIDTH{1'b0}};
                    if (P_CPHA == 1'b0) begin
                        mosi_s = first_bit(i_user_data);
                    end else begin
                        mosi_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (half_end_s) begin
                    state_s   = ST_XFER;
                    div_cnt_s = {DIVW{1'b0}};
                end else begin
                    div_cnt_s = div_cnt_r + DIVW'(1);
                end
            end
            ST_XFER: begin
                if (half_end_s) begin
                    div_cnt_s  = {DIVW{1'b0}};
                    sclk_s     = ~sclk_r;
                    edge_cnt_s = edge_cnt_r + EW'(1);
                    if (leading_s) begin
                        if (P_CPHA == 1'b0) begin
                            rx_s = rx_insert(rx_r, i_spi_miso);
                        end else begin
                            mosi_s = first_bit(tx_r);
                            tx_s   = tx_advance(tx_r);
                        end
                    end else begin
                        if (P_CPHA == 1'b1) begin
                            rx_s = rx_insert(rx_r, i_spi_miso);
                        end else if (edge_cnt_r != EDGE_LAST) begin
                            tx_s   = tx_advance(tx_r);
                            mosi_s = first_bit(tx_advance(tx_r));
                        end else begin
                            tx_s = tx_r;
                        end
                    end
                    if (edge_cnt_r == EDGE_LAST) begin
                        state_s    = ST_HOLD;
                        edge_cnt_s = {EW{1'b0}};
                    end else begin
                        state_s = ST_XFER;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIVW'(1);
                end
            end
            ST_HOLD: begin
                if (half_end_s) begin
                    state_s   = ST_IDLE;
                    div_cnt_s = {DIVW{1'b0}};
                    ready_s   = 1'b1;
                    cs_s      = {P_CS_NUM{1'b1}};
                    sclk_s    = P_CPOL;
                    mosi_s    = 1'b0;
                    udata_s   = rx_r;
                    uvalid_s  = 1'b1;
                end else begin
                    div_cnt_s = div_cnt_r + DIVW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIVW{1'b0}};
            edge_cnt_r <= {EW{1'b0}};
            tx_r       <= {P_DATA_WIDTH{1'b0}};
            rx_r       <= {P_DATA_WIDTH{1'b0}};
            ready_r    <= 1'b1;
            cs_r       <= {P_CS_NUM{1'b1}};
            sclk_r     <= P_CPOL;
            mosi_r     <= 1'b0;
            udata_r    <= {P_DATA_WIDTH{1'b0}};
            uvalid_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_cnt_r  <= div_cnt_s;
            edge_cnt_r <= edge_cnt_s;
            tx_r       <= tx_s;
            rx_r       <= rx_s;
            ready_r    <= ready_s;
            cs_r       <= cs_s;
            sclk_r     <= sclk_s;
            mosi_r     <= mosi_s;
            udata_r    <= udata_s;
            uvalid_r   <= uvalid_s;
        end
    end

    assign o_ready      = ready_r;
    assign o_cs         = cs_r;
    assign o_spi_clk    = sclk_r;
    assign o_spi_mosi   = mosi_r;
    assign o_user_data  = udata_r;
    assign o_user_valid = uvalid_r;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: four mode instances plus a three-select instance, all driven in lockstep.
module tb_spi_master_mc;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] data       = 8'h00;
    logic [1:0] sel        = 2'd0;
    logic       valid      = 1'b0;
    logic       use_slave  = 1'b0;
    logic [7:0] slave_word = 8'h00;

    logic [4:0] rdy_w, mosi_w, miso_w, sclk_w, uvalid_w;
    logic [3:0] cs_w [5];
    logic [2:0] cs3_w;
    logic [7:0] udata_w [5];

    typedef logic [4:0][7:0] exp_t;
    exp_t exp_q[$];

    int         n_chk = 0;
    int         n_err = 0;
    int         tog_cnt [5]    = '{default: 0};
    int         cs_low_cnt [5] = '{default: 0};
    int         tog_base [5]   = '{default: 0};
    int         cs_base [5]    = '{default: 0};
    logic [3:0] cs_cur [5]     = '{default: 4'h0};
    logic [3:0] cs_last [5]    = '{default: 4'h0};
    logic [4:0] sclk_prev;
    bit         acc_in_done;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam bit CPOL_L = ((m / 2) % 2) == 1;
        localparam bit CPHA_L = (m % 2) == 1;
        logic [7:0] sreg = 8'h00;
        logic       sout = 1'b0;
        logic       lead;

        spi_master_mc #(.P_DATA_WIDTH(8), .P_CS_NUM(4), .P_CLK_DIV(2),
                        .P_CPOL(CPOL_L), .P_CPHA(CPHA_L)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_user_data(data), .i_user_cs_sel(sel),
            .i_user_valid(valid), .o_ready(rdy_w[m]), .i_spi_miso(miso_w[m]),
            .o_spi_mosi(mosi_w[m]), .o_spi_clk(sclk_w[m]), .o_cs(cs_w[m]),
            .o_user_data(udata_w[m]), .o_user_valid(uvalid_w[m])
        );

        // Slave on select 2: MSB-first shifter clocked by the SCLK edges of this mode.
        always @(negedge cs_w[m][2]) begin
            sreg = slave_word;
            sout = 1'b0;
            if (!CPHA_L) begin
                sout = sreg[7];
                sreg = {sreg[6:0], 1'b0};
            end
        end
        always @(sclk_w[m]) begin
            if (cs_w[m][2] === 1'b0) begin
                lead = (sclk_w[m] != CPOL_L);
                if (lead == CPHA_L) begin
                    sout = sreg[7];
                    sreg = {sreg[6:0], 1'b0};
                end
            end
        end
        assign miso_w[m] = use_slave ? sout : mosi_w[m];
    end

    spi_master_mc #(.P_DATA_WIDTH(8), .P_CS_NUM(3), .P_CLK_DIV(2),
                    .P_CPOL(1'b0), .P_CPHA(1'b0)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_user_data(data), .i_user_cs_sel(sel),
        .i_user_valid(valid), .o_ready(rdy_w[4]), .i_spi_miso(miso_w[4]),
        .o_spi_mosi(mosi_w[4]), .o_spi_clk(sclk_w[4]), .o_cs(cs3_w),
        .o_user_data(udata_w[4]), .o_user_valid(uvalid_w[4])
    );
    assign miso_w[4] = mosi_w[4];
    assign cs_w[4]   = {1'b1, cs3_w};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit cpol_of(input int i);
        return (i < 4) ? (((i / 2) % 2) == 1) : 1'b0;
    endfunction

    // Edge/CS bookkeeping and scoreboard pop on every received word.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (sclk_w[i] != sclk_prev[i]) tog_cnt[i]++;
            sclk_prev[i] = sclk_w[i];
            if (cs_w[i] != 4'hF) begin
                cs_low_cnt[i]++;
                cs_cur[i] = cs_cur[i] | ~cs_w[i];
            end else if (cs_cur[i] != 4'h0) begin
                cs_last[i] = cs_cur[i];
                cs_cur[i]  = 4'h0;
            end
        end
        if (|uvalid_w) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", {27'd0, uvalid_w}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 5; i++) begin
                    check_eq($sformatf("rx_valid[%0d]", i), {31'd0, uvalid_w[i]}, 32'd1);
                    check_eq($sformatf("rx_data[%0d]", i), {24'd0, udata_w[i]}, {24'd0, e[i]});
                    check_eq($sformatf("cs_high_at_done[%0d]", i), {28'd0, cs_w[i]}, 32'hF);
                    check_eq($sformatf("ready_at_done[%0d]", i), {31'd0, rdy_w[i]}, 32'd1);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] s, input exp_t e,
                        input bit push, input bit keep);
        int n = 0;
        @(negedge clk);
        data  = d;
        sel   = s;
        valid = 1'b1;
        while (!rdy_w[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("accept_timeout", 32'd0, 32'd1);
        acc_in_done = uvalid_w[0];
        if (push) exp_q.push_back(e);
        for (int i = 0; i < 5; i++) begin
            tog_base[i] = tog_cnt[i];
            cs_base[i]  = cs_low_cnt[i];
        end
        @(posedge clk);
        #1;
        if (!keep) valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_eq("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_xfer(input logic [3:0] mask, input int cs_len4);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("sclk_toggles[%0d]", i), tog_cnt[i] - tog_base[i], 32'd16);
            check_eq($sformatf("cs_low_len[%0d]", i), cs_low_cnt[i] - cs_base[i],
                     (i == 4) ? cs_len4 : 36);
            if (i < 4 || cs_len4 != 0)
                check_eq($sformatf("cs_mask[%0d]", i), {28'd0, cs_last[i]}, {28'd0, mask});
            check_eq($sformatf("sclk_idle[%0d]", i), {31'd0, sclk_w[i]}, {31'd0, cpol_of(i)});
            check_eq($sformatf("cs_idle[%0d]", i), {28'd0, cs_w[i]}, 32'hF);
            check_eq($sformatf("mosi_idle[%0d]", i), {31'd0, mosi_w[i]}, 32'd0);
        end
    endtask

    initial begin
        int n;
        logic first_exp;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("rst_ready[%0d]", i), {31'd0, rdy_w[i]}, 32'd1);
            check_eq($sformatf("rst_cs[%0d]", i), {28'd0, cs_w[i]}, 32'hF);
            check_eq($sformatf("rst_sclk[%0d]", i), {31'd0, sclk_w[i]}, {31'd0, cpol_of(i)});
            check_eq($sformatf("rst_mosi[%0d]", i), {31'd0, mosi_w[i]}, 32'd0);
            check_eq($sformatf("rst_udata[%0d]", i), {24'd0, udata_w[i]}, 32'd0);
            check_eq($sformatf("rst_uvalid[%0d]", i), {31'd0, uvalid_w[i]}, 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback of A5 on select 0 in all four modes.
        send(8'hA5, 2'd0, {5{8'hA5}}, 1'b1, 1'b0);
        wait_idle();
        check_xfer(4'b0001, 36);

        // Slave returns 3C on select 2; input changes after accept must not matter.
        use_slave  = 1'b1;
        slave_word = 8'h3C;
        send(8'h96, 2'd2, {8'h96, 8'h3C, 8'h3C, 8'h3C, 8'h3C}, 1'b1, 1'b0);
        data = 8'h00;
        sel  = 2'd1;
        wait_idle();
        check_xfer(4'b0100, 36);
        use_slave = 1'b0;

        // Select 3: asserts o_cs[3] on the 4-select parts, nothing on the 3-select part.
        send(8'hC3, 2'd3, {5{8'hC3}}, 1'b1, 1'b0);
        wait_idle();
        check_xfer(4'b1000, 0);

        // Held valid: the second word is taken in the completion cycle of the first.
        send(8'h01, 2'd0, {5{8'h01}}, 1'b1, 1'b1);
        send(8'hFE, 2'd0, {5{8'hFE}}, 1'b1, 1'b0);
        check_eq("b2b_accept_in_valid_cycle", {31'd0, acc_in_done}, 32'd1);
        wait_idle();
        check_xfer(4'b0001, 36);

        // Reset at the fifth SCLK toggle aborts without a completion pulse.
        send(8'hA5, 2'd1, {5{8'hA5}}, 1'b0, 1'b0);
        n = 0;
        while ((tog_cnt[0] - tog_base[0]) < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("toggle5_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("abort_cs[%0d]", i), {28'd0, cs_w[i]}, 32'hF);
            check_eq($sformatf("abort_sclk[%0d]", i), {31'd0, sclk_w[i]}, {31'd0, cpol_of(i)});
            check_eq($sformatf("abort_ready[%0d]", i), {31'd0, rdy_w[i]}, 32'd1);
            check_eq($sformatf("abort_uvalid[%0d]", i), {31'd0, uvalid_w[i]}, 32'd0);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        send(8'h5A, 2'd0, {5{8'h5A}}, 1'b1, 1'b0);
        wait_idle();
        check_xfer(4'b0001, 36);

        // First bit on MOSI shows the shift order; the block is busy right after accept.
`ifdef SPI_LSB_FIRST_EN
        first_exp = 1'b1;
`else
        first_exp = 1'b0;
`endif
        send(8'h01, 2'd1, {5{8'h01}}, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("first_mosi_bit", {31'd0, mosi_w[0]}, {31'd0, first_exp});
        check_eq("busy_after_accept", {31'd0, rdy_w[0]}, 32'd0);
        wait_idle();
        check_xfer(4'b0010, 36);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
